// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: VGA scan reads, gameplay write/read ports and a
// board-clear sequencer share one RAM; every RAM strobe and response is registered.
module board_mem_arbiter #(
    parameter int                ADDR_W     = 7,
    parameter int                DATA_W     = 2,
    parameter int                CELLS      = 100,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
    parameter int                STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic              mem_oe
);

    localparam int CNT_W = $clog2(CELLS + 1);
    localparam int SV_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CELLS);
    localparam logic [SV_W-1:0]  STARVE_LIM = SV_W'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_ARB,
        ST_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [SV_W-1:0]   starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_oe_q, mem_oe_d;
    logic              wr_ack_q, wr_ack_d;
    logic              clear_busy_q, clear_busy_d;
    logic              clear_done_q, clear_done_d;
    logic              rd_p1_q, rd_p1_d;
    logic              scan_p1_q, scan_p1_d;
    logic              zero_p1_q, zero_p1_d;
    logic              rd_valid_q, rd_valid_d;
    logic              scan_valid_q, scan_valid_d;
    logic              zero_q, zero_d;

    logic grant_scan, grant_wr, grant_rd;
    logic rd_pending, gp_pending, starved;
    logic scan_in_range, wr_in_range, rd_in_range;

    assign scan_in_range = int'(scan_addr) < CELLS;
    assign wr_in_range   = int'(wr_addr) < CELLS;
    assign rd_in_range   = int'(rd_addr) < CELLS;

    // A held rd_req is not re-granted while its own read is still in the pipe.
    assign rd_pending = rd_req & ~rd_p1_q;
    assign gp_pending = wr_req | rd_pending;
    assign starved    = (starve_q == STARVE_LIM);

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        starve_d     = starve_q;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_we_d     = 1'b0;
        mem_oe_d     = 1'b0;
        wr_ack_d     = 1'b0;
        clear_busy_d = 1'b0;
        clear_done_d = 1'b0;
        rd_p1_d      = 1'b0;
        scan_p1_d    = 1'b0;
        zero_p1_d    = 1'b0;
        rd_valid_d   = rd_p1_q;
        scan_valid_d = scan_p1_q;
        zero_d       = zero_p1_q;
        grant_scan   = 1'b0;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (clear_start) begin
                    state_d      = ST_CLEAR;
                    mem_we_d     = 1'b1;
                    mem_wdata_d  = CLEAR_VAL;
                    clr_cnt_d    = CNT_W'(1);
                    clear_busy_d = 1'b1;
                end else if (starved && gp_pending) begin
                    grant_wr = wr_req;
                    grant_rd = ~wr_req;
                end else if (scan_req) begin
                    grant_scan = 1'b1;
                end else if (wr_req) begin
                    grant_wr = 1'b1;
                end else if (rd_pending) begin
                    grant_rd = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d      = ST_ARB;
                    clr_cnt_d    = '0;
                    clear_done_d = 1'b1;
                end else begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = ADDR_W'(clr_cnt_q);
                    mem_wdata_d  = CLEAR_VAL;
                    clr_cnt_d    = clr_cnt_q + CNT_W'(1);
                    clear_busy_d = 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase

        // Out-of-range accesses still complete their handshake but never touch the RAM.
        if (grant_scan) begin
            scan_p1_d = 1'b1;
            if (scan_in_range) begin
                mem_oe_d   = 1'b1;
                mem_addr_d = scan_addr;
            end else begin
                zero_p1_d = 1'b1;
            end
        end
        if (grant_wr) begin
            wr_ack_d = 1'b1;
            if (wr_in_range) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data;
            end
        end
        if (grant_rd) begin
            rd_p1_d = 1'b1;
            if (rd_in_range) begin
                mem_oe_d   = 1'b1;
                mem_addr_d = rd_addr;
            end else begin
                zero_p1_d = 1'b1;
            end
        end

        if (grant_wr || grant_rd) begin
            starve_d = '0;
        end else if (gp_pending && !starved) begin
            starve_d = starve_q + SV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARB;
            clr_cnt_q    <= '0;
            starve_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_oe_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            rd_p1_q      <= 1'b0;
            scan_p1_q    <= 1'b0;
            zero_p1_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            scan_valid_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            starve_q     <= starve_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_oe_q     <= mem_oe_d;
            wr_ack_q     <= wr_ack_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
            rd_p1_q      <= rd_p1_d;
            scan_p1_q    <= scan_p1_d;
            zero_p1_q    <= zero_p1_d;
            rd_valid_q   <= rd_valid_d;
            scan_valid_q <= scan_valid_d;
            zero_q       <= zero_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_oe     = mem_oe_q;
    assign wr_ack     = wr_ack_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;
    assign rd_valid   = rd_valid_q;
    assign scan_valid = scan_valid_q;
    // The RAM presents its data in the valid cycle, so responses pass it straight through.
    assign rd_data    = (rd_valid_q && !zero_q) ? mem_rdata : '0;
    assign scan_data  = (scan_valid_q && !zero_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: behavioural synchronous RAM, table-driven
// gameplay transactions with a read scoreboard, and hand-written multi-cycle sequences.
module tb_board_mem_arbiter;

    localparam int CELLS = 100;

    logic       clk;
    logic       reset;
    logic       clear_start;
    logic       clear_busy;
    logic       clear_done;
    logic       scan_req;
    logic [6:0] scan_addr;
    logic [1:0] scan_data;
    logic       scan_valid;
    logic       wr_req;
    logic [6:0] wr_addr;
    logic [1:0] wr_data;
    logic       wr_ack;
    logic       rd_req;
    logic [6:0] rd_addr;
    logic [1:0] rd_data;
    logic       rd_valid;
    logic [6:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;
    logic       mem_we;
    logic       mem_oe;

    board_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_data   (scan_data),
        .scan_valid  (scan_valid),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .mem_oe      (mem_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: data of an mem_oe cycle appears in the following cycle.
    logic [1:0] ram [128];
    logic       ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 128; i++) ram[i] <= (i == 12) ? 2'b10 : 2'(i % 4);
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_oe) mem_rdata <= ram[mem_addr];
        end
    end

    int tests_run = 0;
    int tests_failed = 0;
    int we_oe_viol = 0;
    int oob_we = 0;
    logic [1:0] rd_exp_q [$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Bus protocol watch plus the read scoreboard, sampled mid-cycle.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (mem_we && mem_oe) we_oe_viol++;
            if (mem_we && int'(mem_addr) >= CELLS) oob_we++;
            if (!reset && rd_valid) begin
                if (rd_exp_q.size() == 0) begin
                    checkOutput("rd_spurious_valid", 1, 0);
                end else begin
                    e = rd_exp_q.pop_front();
                    checkOutput("rd_data", int'(rd_data), int'(e));
                end
            end
        end
    end

    typedef struct {
        bit         is_rd;
        logic [6:0] addr;
        logic [1:0] wdata;
        bit         exp_we;
        logic [1:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    // One gameplay transaction; entered and left just after a rising edge.
    task automatic applyStimulus(input vec_t v);
        int got;
        got = 0;
        if (!v.is_rd) begin
            wr_addr = v.addr;
            wr_data = v.wdata;
            wr_req  = 1'b1;
            for (int c = 0; c < 20 && got == 0; c++) begin
                @(posedge clk); #1;
                if (wr_ack) got = 1;
            end
            checkOutput("wr_ack_seen", got, 1);
            if (got == 1) begin
                checkOutput("wr_mem_we", int'(mem_we), int'(v.exp_we));
                if (v.exp_we) begin
                    checkOutput("wr_mem_addr", int'(mem_addr), int'(v.addr));
                    checkOutput("wr_mem_wdata", int'(mem_wdata), int'(v.wdata));
                end
            end
            wr_req = 1'b0;
        end else begin
            rd_exp_q.push_back(v.exp_rdata);
            rd_addr = v.addr;
            rd_req  = 1'b1;
            for (int c = 0; c < 20 && got == 0; c++) begin
                @(posedge clk); #1;
                if (rd_valid) got = 1;
            end
            checkOutput("rd_valid_seen", got, 1);
            rd_req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int found, got_ack, got_rd, oe_before, sv_gap, sd_err, ack_k;
        int we_cnt, seq_err, busy_cnt, done_cnt, done_k;

        vecs[0]  = '{is_rd: 1'b0, addr: 7'd7,   wdata: 2'b11, exp_we: 1'b1, exp_rdata: 2'b00};
        vecs[1]  = '{is_rd: 1'b1, addr: 7'd7,   wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b11};
        vecs[2]  = '{is_rd: 1'b1, addr: 7'd13,  wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b01};
        vecs[3]  = '{is_rd: 1'b0, addr: 7'd99,  wdata: 2'b01, exp_we: 1'b1, exp_rdata: 2'b00};
        vecs[4]  = '{is_rd: 1'b1, addr: 7'd99,  wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b01};
        vecs[5]  = '{is_rd: 1'b0, addr: 7'd100, wdata: 2'b10, exp_we: 1'b0, exp_rdata: 2'b00};
        vecs[6]  = '{is_rd: 1'b1, addr: 7'd100, wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b00};
        vecs[7]  = '{is_rd: 1'b1, addr: 7'd127, wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b00};
        vecs[8]  = '{is_rd: 1'b0, addr: 7'd0,   wdata: 2'b10, exp_we: 1'b1, exp_rdata: 2'b00};
        vecs[9]  = '{is_rd: 1'b1, addr: 7'd0,   wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b10};
        vecs[10] = '{is_rd: 1'b0, addr: 7'd127, wdata: 2'b11, exp_we: 1'b0, exp_rdata: 2'b00};
        vecs[11] = '{is_rd: 1'b1, addr: 7'd2,   wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b10};

        reset = 1'b1; ram_init = 1'b1; clear_start = 1'b0;
        scan_req = 1'b0; scan_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_flags", int'({clear_busy, clear_done, scan_valid, wr_ack, rd_valid, mem_we, mem_oe}), 0);
        checkOutput("rst_mem_addr", int'(mem_addr), 0);
        checkOutput("rst_mem_wdata", int'(mem_wdata), 0);
        checkOutput("rst_data_out", int'({rd_data, scan_data}), 0);
        ram_init = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        // Idle bus read: mem_oe one cycle after sampling, rd_valid one cycle later.
        rd_exp_q.push_back(2'b10);
        rd_addr = 7'd12; rd_req = 1'b1;
        @(posedge clk); #1;
        checkOutput("t3_mem_oe", int'(mem_oe), 1);
        checkOutput("t3_mem_addr", int'(mem_addr), 12);
        checkOutput("t3_no_early_valid", int'(rd_valid), 0);
        @(posedge clk); #1;
        checkOutput("t3_rd_valid_n2", int'(rd_valid), 1);
        rd_req = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // Simultaneous write and read to the same cell: the read must see the new value.
        wr_addr = 7'd3; wr_data = 2'b01; rd_addr = 7'd3;
        wr_req = 1'b1; rd_req = 1'b1;
        rd_exp_q.push_back(2'b01);
        got_ack = 0; got_rd = 0;
        for (int c = 0; c < 20 && !(got_ack == 1 && got_rd == 1); c++) begin
            @(posedge clk); #1;
            if (wr_ack && got_ack == 0) begin
                got_ack = 1;
                checkOutput("t4_wr_we", int'(mem_we), 1);
                checkOutput("t4_wr_no_oe", int'(mem_oe), 0);
                wr_req = 1'b0;
            end
            if (rd_valid) begin
                got_rd = 1;
                rd_req = 1'b0;
                checkOutput("t4_rd_after_wr", got_ack, 1);
            end
        end
        checkOutput("t4_ack_seen", got_ack, 1);
        checkOutput("t4_rd_seen", got_rd, 1);
        @(posedge clk); #1;

        // Scan held high starves a write for exactly four scan grants.
        scan_addr = 7'd21; scan_req = 1'b1;
        wr_addr = 7'd5; wr_data = 2'b01; wr_req = 1'b1;
        oe_before = 0; ack_k = 0; sv_gap = 0; sd_err = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ack_k == 0 && mem_oe) oe_before++;
            if (wr_ack && ack_k == 0) begin
                ack_k = k;
                checkOutput("t2_wr_we", int'(mem_we), 1);
                checkOutput("t2_wr_addr", int'(mem_addr), 5);
                checkOutput("t2_wr_wdata", int'(mem_wdata), 1);
                wr_req = 1'b0;
            end
            if (k >= 2 && !scan_valid) sv_gap++;
            if (scan_valid && scan_data != 2'b01) sd_err++;
        end
        checkOutput("t2_scan_grants_before_wr", oe_before, 4);
        checkOutput("t2_ack_cycle", ack_k, 5);
        checkOutput("t2_scan_valid_gaps", sv_gap, 1);
        checkOutput("t2_scan_data_errs", sd_err, 0);
        scan_req = 1'b0; wr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Board clear with a write held pending; the write must wait until clear ends.
        wr_addr = 7'd50; wr_data = 2'b11; wr_req = 1'b1;
        clear_start = 1'b1;
        we_cnt = 0; seq_err = 0; busy_cnt = 0; done_cnt = 0; done_k = 0; ack_k = 0;
        for (int k = 1; k <= 110; k++) begin
            @(posedge clk); #1;
            if (k == 1) clear_start = 1'b0;
            if (k <= 100 && !(mem_we && int'(mem_addr) == k - 1 && mem_wdata == 2'b00)) seq_err++;
            if (k <= 101 && mem_we) we_cnt++;
            if (clear_busy) busy_cnt++;
            if (clear_done) begin
                done_cnt++;
                done_k = k;
            end
            if (wr_ack && ack_k == 0) begin
                ack_k = k;
                wr_req = 1'b0;
            end
        end
        checkOutput("t1_clear_writes", we_cnt, 100);
        checkOutput("t1_clear_addr_seq_errs", seq_err, 0);
        checkOutput("t1_busy_cycles", busy_cnt, 100);
        checkOutput("t1_done_pulses", done_cnt, 1);
        checkOutput("t1_done_cycle", done_k, 101);
        checkOutput("t1_stalled_wr_ack_cycle", ack_k, 102);
        wr_req = 1'b0;
        applyStimulus('{is_rd: 1'b1, addr: 7'd60, wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b00});
        applyStimulus('{is_rd: 1'b1, addr: 7'd50, wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b11});

        // Reset partway through a clear, then a fresh clear from address 0.
        clear_start = 1'b1;
        found = 0;
        for (int c = 1; c <= 60 && found == 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) clear_start = 1'b0;
            if (mem_we && mem_addr == 7'd40) found = 1;
        end
        checkOutput("t6_reached_addr40", found, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("t6_busy_after_reset", int'(clear_busy), 0);
        checkOutput("t6_we_after_reset", int'(mem_we), 0);
        reset = 1'b0;
        done_cnt = 0; we_cnt = 0;
        repeat (110) begin
            @(posedge clk); #1;
            if (clear_done) done_cnt++;
            if (mem_we) we_cnt++;
        end
        checkOutput("t6_no_done_after_reset", done_cnt, 0);
        checkOutput("t6_no_writes_after_reset", we_cnt, 0);
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        checkOutput("t6_restart_we", int'(mem_we), 1);
        checkOutput("t6_restart_addr", int'(mem_addr), 0);
        found = 0;
        for (int c = 0; c < 120 && found == 0; c++) begin
            @(posedge clk); #1;
            if (clear_done) found = 1;
        end
        checkOutput("t6_restart_done", found, 1);
        applyStimulus('{is_rd: 1'b1, addr: 7'd40, wdata: 2'b00, exp_we: 1'b0, exp_rdata: 2'b00});

        repeat (3) @(posedge clk);
        #1;
        checkOutput("we_oe_exclusive_viol", we_oe_viol, 0);
        checkOutput("oob_write_strobes", oob_we, 0);
        checkOutput("rd_scoreboard_left", rd_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
